instr_ctrl_fsm: RTL and testbench

//  Multi-cycle control stage that sits directly upstream of the reg_file -> mux -> alu datapath.

---
 rtl/instr_ctrl_fsm.sv | 144 ++++++++++++++
 tb/tb_instr_ctrl_fsm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_ctrl_fsm.sv
// Multi-cycle IDLE/DECODE/EXEC/WB control stage for the reg_file -> mux -> alu datapath.
// Accepts one 16-bit instruction per visit to IDLE and sequences its decode, execute and writeback.
module instr_ctrl_fsm #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned REG_ADDR_W   = 3,
  parameter bit          OVF_BLOCK_WB = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [DATA_W-1:0]     instr,
  output logic                  instr_ready,
  output logic [REG_ADDR_W-1:0] rd0_addr,
  output logic [REG_ADDR_W-1:0] rd1_addr,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  RegWrite,
  output logic                  ALUSrc1,
  output logic                  ALUSrc2,
  output logic [DATA_W-1:0]     alu_input2_instr_src,
  output logic [2:0]            ALUOp,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_take_branch,
  input  logic                  alu_ovf,
  output logic                  done,
  output logic                  branch_taken,
  output logic                  ovf_flag,
  output logic                  illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_result_q;
  logic              r_regwrite;
  logic              r_done;
  logic              r_illegal;
  logic              r_branch;
  logic              r_ovf_flag;

  logic [3:0]        w_op;
  logic              w_wb_op;
  logic              w_illegal_op;
  logic              w_src1;
  logic              w_src2;
  logic [2:0]        w_aluop;
  logic [DATA_W-1:0] w_imm;

  assign w_op         = r_ir[15:12];
  assign w_wb_op      = (w_op == 4'd0) || (w_op == 4'd1) || (w_op == 4'd2);
  assign w_illegal_op = (w_op[3:2] != 2'b00);

  // Controls decode straight from IR, so they appear in DECODE and stay fixed until the next transfer.
  always_comb begin
    w_src1  = 1'b0;
    w_src2  = 1'b0;
    w_aluop = 3'b000;
    w_imm   = '0;
    case (w_op)
      4'd0: w_aluop = r_ir[2:0];
      4'd1: begin
        w_src2 = 1'b1;
        w_imm  = {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]};
      end
      4'd2: begin
        w_src1 = 1'b1;
        w_src2 = 1'b1;
        w_imm  = {{(DATA_W-9){r_ir[8]}}, r_ir[8:0]};
      end
      4'd3: w_aluop = r_ir[2:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_result_q <= '0;
      r_regwrite <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_branch   <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else begin
      r_regwrite <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_illegal_op) begin
            r_done    <= 1'b1;
            r_illegal <= 1'b1;
            r_state   <= S_WB;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result_q <= alu_result;
          r_done     <= 1'b1;
          // Writeback ops feed the sticky flag; the only other legal op here is BR.
          if (w_wb_op) begin
            r_ovf_flag <= r_ovf_flag | alu_ovf;
            r_regwrite <= !(OVF_BLOCK_WB && alu_ovf);
          end else begin
            r_branch <= alu_take_branch;
          end
          r_state <= S_WB;
        end
        S_WB: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready          = (r_state == S_IDLE);
  assign rd0_addr             = r_ir[8:6];
  assign rd1_addr             = r_ir[5:3];
  assign wr_addr              = r_ir[11:9];
  assign wr_data              = r_result_q;
  assign RegWrite             = r_regwrite;
  assign ALUSrc1              = w_src1;
  assign ALUSrc2              = w_src2;
  assign alu_input2_instr_src = w_imm;
  assign ALUOp                = w_aluop;
  assign done                 = r_done;
  assign branch_taken         = r_branch;
  assign ovf_flag             = r_ovf_flag;
  assign illegal              = r_illegal;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Bench: instr_ctrl_fsm driving a behavioural reg_file, operand muxes and ALU,
// checked instruction-by-instruction against an architectural register model.
module tb_instr_ctrl_fsm;

  localparam bit OVF_BLOCK = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rd0_addr, rd1_addr, wr_addr;
  logic [15:0] wr_data;
  logic        RegWrite, ALUSrc1, ALUSrc2;
  logic [15:0] alu_input2_instr_src;
  logic [2:0]  ALUOp;
  logic [15:0] alu_result;
  logic        alu_take_branch, alu_ovf;
  logic        done, branch_taken, ovf_flag, illegal;

  always #5 clk = ~clk;

  instr_ctrl_fsm #(.DATA_W(16), .REG_ADDR_W(3), .OVF_BLOCK_WB(OVF_BLOCK)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .wr_addr(wr_addr), .wr_data(wr_data),
    .RegWrite(RegWrite), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
    .alu_input2_instr_src(alu_input2_instr_src), .ALUOp(ALUOp), .alu_result(alu_result),
    .alu_take_branch(alu_take_branch), .alu_ovf(alu_ovf), .done(done),
    .branch_taken(branch_taken), .ovf_flag(ovf_flag), .illegal(illegal)
  );

  // ALU environment: op 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 srl1, 6 slt, 7 pass b
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic v, t;
    r = '0; v = 1'b0; t = 1'b0;
    case (op)
      3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); t = (a == b); end
      3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); t = (a != b); end
      3'd2: begin r = a & b; t = ($signed(a) < $signed(b)); end
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = {1'b0, a[15:1]};
      3'd6: r = {15'b0, ($signed(a) < $signed(b))};
      default: r = b;
    endcase
    return {t, v, r};
  endfunction

  logic [15:0] rf [8] = '{default: '0};
  int          wr_count = 0;
  logic [15:0] w_in1, w_in2;

  always @(posedge clk) begin
    if (RegWrite) begin
      rf[wr_addr] <= wr_data;
      wr_count    <= wr_count + 1;
    end
  end

  assign w_in1 = ALUSrc1 ? 16'h0000 : rf[rd0_addr];
  assign w_in2 = ALUSrc2 ? alu_input2_instr_src : rf[rd1_addr];
  assign {alu_take_branch, alu_ovf, alu_result} = alu_f(ALUOp, w_in1, w_in2);

  logic [15:0] m_rf [8] = '{default: '0};
  logic        m_ovf = 1'b0;
  logic        m_br  = 1'b0;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_instr(input logic [15:0] ins);
    logic [3:0]  op;
    logic [2:0]  rd, rs0, rs1, fn;
    logic        src1, src2, writes, v, t;
    logic [15:0] imm, a, b, res;
    int          sa, sb, n;
    op = ins[15:12]; rd = ins[11:9]; rs0 = ins[8:6]; rs1 = ins[5:3]; fn = ins[2:0];
    src1 = (op == 4'd2);
    src2 = (op == 4'd1) || (op == 4'd2);
    imm  = (op == 4'd1) ? {{10{ins[5]}}, ins[5:0]} : (op == 4'd2) ? {{7{ins[8]}}, ins[8:0]} : 16'h0;
    a    = src1 ? 16'h0 : m_rf[rs0];
    b    = src2 ? imm : m_rf[rs1];
    if (op == 4'd0 || op == 4'd3) begin
      {t, v, res} = alu_f(fn, a, b);
    end else begin
      sa = $signed(a); sb = $signed(b);
      res = a + b;
      v = (sa + sb > 32767) || (sa + sb < -32768);
      t = 1'b0;
    end
    writes = (op <= 4'd2) && !(OVF_BLOCK && v);

    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    check("ready_wait", instr_ready, 1);
    if (!instr_ready) return;
    instr_valid = 1'b1;
    instr = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("dec_ready", instr_ready, 0);
    check("dec_done", done, 0);
    check("rd0_addr", rd0_addr, rs0);
    check("rd1_addr", rd1_addr, rs1);
    if (op <= 4'd3) begin
      check("ALUSrc1", ALUSrc1, src1);
      check("ALUSrc2", ALUSrc2, src2);
      check("ALUOp", ALUOp, (op == 4'd0 || op == 4'd3) ? fn : 3'd0);
      if (src2) check("imm", alu_input2_instr_src, imm);
    end
    if (op > 4'd3) begin
      @(posedge clk); #1;
      check("ill_illegal", illegal, 1);
      check("ill_done", done, 1);
      check("ill_regwrite", RegWrite, 0);
    end else begin
      @(posedge clk); #1;
      check("exec_done", done, 0);
      check("exec_regwrite", RegWrite, 0);
      @(posedge clk); #1;
      if (op <= 4'd2) m_ovf = m_ovf | v;
      if (op == 4'd3) m_br = t;
      check("wb_done", done, 1);
      check("wb_illegal", illegal, 0);
      check("wb_regwrite", RegWrite, writes);
      check("wb_wr_addr", wr_addr, rd);
      check("wb_wr_data", wr_data, res);
      check("wb_ovf_flag", ovf_flag, m_ovf);
      check("wb_branch", branch_taken, m_br);
      if (writes) m_rf[rd] = res;
    end
    @(posedge clk); #1;
    check("post_done", done, 0);
    check("post_illegal", illegal, 0);
    check("post_ready", instr_ready, 1);
    check("post_branch", branch_taken, m_br);
    for (int i = 0; i < 8; i++) check($sformatf("rf%0d", i), rf[i], m_rf[i]);
  endtask

  initial begin
    int xfers, wc0, r;
    logic [15:0] ins;
    instr_valid = 1'b0;
    instr = '0;
    rst = 1'b1;
    #10 rst = 1'b0;
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_regwrite", RegWrite, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_branch", branch_taken, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd0", rd0_addr, 0);
    check("rst_src", {ALUSrc1, ALUSrc2}, 0);
    check("rst_imm", alu_input2_instr_src, 0);
    check("rst_aluop", ALUOp, 0);

    run_instr(16'h220C);
    check("li_r1", rf[1], 16'h000C);
    run_instr(16'h147F);
    check("addi_r2", rf[2], 16'h000B);
    run_instr(16'h27FF);
    run_instr(16'h06C5);
    check("r3_pre", rf[3], 16'h7FFF);
    run_instr(16'h16C1);
    check("ovf_sticky", ovf_flag, 1);
    check("r3_ovf", rf[3], OVF_BLOCK ? 16'h7FFF : 16'h8000);
    wc0 = wr_count;
    run_instr(16'hF000);
    check("illegal_nowrite", wr_count, wc0);

    // instr_valid held high: one transfer per IDLE visit
    @(negedge clk);
    wc0 = wr_count;
    xfers = 0;
    instr_valid = 1'b1;
    instr = 16'h2A07;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid && instr_ready) xfers++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    m_rf[5] = 16'h0007;
    check("hold_xfers", xfers, 5);
    check("hold_writes", wr_count - wc0, 5);
    check("hold_r5", rf[5], 16'h0007);

    // reset during EXEC of LI r4,5
    run_instr(16'h29FF);
    @(negedge clk);
    wc0 = wr_count;
    instr_valid = 1'b1;
    instr = 16'h2805;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    m_ovf = 1'b0;
    m_br  = 1'b0;
    check("arst_ready", instr_ready, 1);
    check("arst_regwrite", RegWrite, 0);
    check("arst_done", done, 0);
    check("arst_ovf", ovf_flag, 0);
    check("arst_wr_data", wr_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("arst_r4", rf[4], 16'hFFFF);
    check("arst_nowrite", wr_count, wc0);

    for (int k = 0; k < 80; k++) begin
      ins = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 2)      ins[15:12] = 4'd0;
      else if (r <= 4) ins[15:12] = 4'd1;
      else if (r <= 6) ins[15:12] = 4'd2;
      else if (r <= 8) ins[15:12] = 4'd3;
      else             ins[15:12] = 4'($urandom_range(4, 15));
      run_instr(ins);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
